mux_n_reg: RTL and testbench
============================

Name: mux_n_reg

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer for ReSDMAC datapath steering, e.g. selecting the source for FIFO/bus data paths.
- The channel select is held in a select register and only changes on an explicit load strobe.
- The selected data is captured into a single-stage output register with a valid/ready handshake, so a select change never glitches a pending output beat.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- CHANNELS, 4, number of input channels (>=2).
- SEL_W, $clog2(CHANNELS), select width. Derived; do not override.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- nRST  input  1  asynchronous active-low reset.
- D  input  CHANNELS*WIDTH  flattened channel data; channel k occupies D[k*WIDTH +: WIDTH].
- SEL  input  SEL_W  new channel select value.
- SEL_LD  input  1  load strobe: SEL is written into the select register on this edge.
- SEL_Q  output  SEL_W  current registered select.
- IN_VALID  input  1  upstream asserts that a beat is available on D.
- IN_READY  output  1  block can accept a beat this cycle.
- Z  output  WIDTH  registered output data.
- OUT_VALID  output  1  Z holds a beat not yet consumed.
- OUT_READY  input  1  downstream consumes Z this cycle when OUT_VALID=1.
- SEL_ERR  output  1  select-range error pulse. Present only with MUXN_SEL_CHECK_EN.

Behaviour:
- Reset (nRST=0, asynchronous): SEL_Q=0, Z=0, OUT_VALID=0, SEL_ERR=0. IN_READY then reads 1.
- Clock and reset: one clock, CLK; reset is asynchronous and active-low, nRST.
- IN_READY = !OUT_VALID || OUT_READY. It is combinational and never depends on IN_VALID (no loop).
- Capture happens when IN_VALID && IN_READY:
  - Z <= D[SEL_Q*WIDTH +: WIDTH], using the SEL_Q value before the edge.
  - OUT_VALID <= 1.
  - Latency: 1 clock from accepted beat to Z/OUT_VALID.
- Drain: OUT_VALID && OUT_READY && !(IN_VALID && IN_READY) -> OUT_VALID <= 0. Z keeps its last value.
- Simultaneous drain and capture: a new beat replaces the old one and OUT_VALID stays 1. This gives full throughput of 1 beat/clock.
- Back-pressure: while OUT_VALID=1 and OUT_READY=0, Z and OUT_VALID are held and IN_READY=0. Input beats are not lost; upstream holds them.
- Select register:
  - SEL_LD=1 -> SEL_Q <= SEL at the edge.
  - It is independent of the handshake and may load while a beat is pending.
  - A pending Z is never altered by a select change.
- SEL_LD in the same cycle as a capture: the capture uses the old SEL_Q; the new select applies from the next beat.
- Out-of-range select (SEL_Q >= CHANNELS, possible only when CHANNELS is not a power of 2): the captured data is all zeros and the handshake proceeds normally.
- SEL input is unused when SEL_LD=0.
- Reset mid-operation: a pending beat is discarded (OUT_VALID=0) and the select returns to channel 0.
- No other state. X on D for unselected channels must not propagate to Z.

Optional Feature:
- Macro: MUXN_SEL_CHECK_EN.
- Defined:
  - SEL_LD with SEL >= CHANNELS is rejected, so SEL_Q is unchanged.
  - SEL_ERR pulses 1 for exactly one clock on the following cycle.
  - A valid load never asserts SEL_ERR.
  - The SEL_ERR port exists.
- Undefined:
  - The SEL_ERR port is absent.
  - An out-of-range SEL is loaded as-is and subsequent captures yield zero.
- With CHANNELS a power of 2, the feature is inert: SEL_ERR stays 0.

Test Plan:
- Reset/idle: assert nRST=0 mid-beat with OUT_VALID=1 -> Z=0, OUT_VALID=0, SEL_Q=0, IN_READY=1 immediately (asynchronous).
- Basic select, WIDTH=32, CHANNELS=4, D = {ch3=0xDDDD0003, ch2=0xCCCC0002, ch1=0xBBBB0001, ch0=0xAAAA0000}:
  - SEL_LD with SEL=2, then IN_VALID one cycle -> next clock Z=0xCCCC0002, OUT_VALID=1.
- Same-cycle load and capture: SEL_Q=1; SEL_LD with SEL=3 and IN_VALID in the same cycle -> Z=0xBBBB0001; the next beat gives Z=0xDDDD0003.
- Back-pressure: OUT_READY=0 for 5 cycles with IN_VALID=1 -> IN_READY=0 and Z stable for all 5 cycles. OUT_READY=1 -> one drain/capture per clock with no lost or duplicated beats (count 8 beats in = 8 out).
- Streaming: IN_VALID=OUT_READY=1 continuously, D[ch0] incrementing 0..15 -> Z follows with 1-clock lag and OUT_VALID stays 1.
- CHANNELS=3 out-of-range:
  - With MUXN_SEL_CHECK_EN: SEL_LD with SEL=3 -> SEL_Q unchanged, SEL_ERR=1 for one clock.
  - Without: SEL_Q=3 and a captured beat gives Z=0.

Source files
------------

// File: rtl/mux_n_reg.sv
// rtl/mux_n_reg.sv - N-channel registered multiplexer with load-strobed select and valid/ready output stage
//
// Purpose:
//   Steers one of CHANNELS WIDTH-bit inputs into a single output register.
//   The channel select lives in its own register and changes only on SEL_LD.
//   The output register is a one-deep valid/ready stage, so a select change
//   never disturbs a beat that is already sitting in Z.
//
// Optional feature (macro MUXN_SEL_CHECK_EN):
//   defined   - out-of-range select loads are rejected and reported on SEL_ERR
//   undefined - SEL_ERR is absent; any SEL value loads as-is
//
// Ports:
//   CLK        in   system clock, rising edge
//   nRST       in   asynchronous active-low reset
//   D          in   flattened channel data, channel k at D[k*WIDTH +: WIDTH]
//   SEL        in   new channel select, used only with SEL_LD
//   SEL_LD     in   select load strobe
//   SEL_Q      out  current registered select
//   IN_VALID   in   upstream beat available on D
//   IN_READY   out  block accepts a beat this cycle
//   Z          out  registered output data
//   OUT_VALID  out  Z holds an unconsumed beat
//   OUT_READY  in   downstream consumes Z this cycle
//   SEL_ERR    out  one-clock out-of-range load pulse (MUXN_SEL_CHECK_EN only)

module mux_n_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [SEL_W-1:0]          SEL,
    input  logic                      SEL_LD,
    output logic [SEL_W-1:0]          SEL_Q,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    output logic [WIDTH-1:0]          Z,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY
`ifdef MUXN_SEL_CHECK_EN
    ,
    output logic                      SEL_ERR
`endif
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] mux_data;
    logic             capture;

    // Ready depends only on the output stage, never on IN_VALID.
    assign IN_READY = !out_valid_q || OUT_READY;
    assign capture  = IN_VALID && IN_READY;

    // Only the matching channel is ever read, so X on unselected channels
    // cannot reach Z; a select beyond the last channel yields zero.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(sel_q) == k) begin
                mux_data = D[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUXN_SEL_CHECK_EN
    logic sel_bad;
    logic sel_err_q, sel_err_d;

    assign sel_bad   = int'(SEL) >= CHANNELS;
    assign sel_err_d = SEL_LD && sel_bad;
    assign SEL_ERR   = sel_err_q;

    always_comb begin
        sel_d = sel_q;
        if (SEL_LD && !sel_bad) begin
            sel_d = SEL;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end
`else
    always_comb begin
        sel_d = sel_q;
        if (SEL_LD) begin
            sel_d = SEL;
        end
    end
`endif

    // Capture wins over drain: a simultaneous drain and capture keeps the
    // stage full with the new beat.
    always_comb begin
        z_d         = z_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            z_d         = mux_data;
            out_valid_d = 1'b1;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sel_q       <= '0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign SEL_Q     = sel_q;
    assign Z         = z_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// tb/tb_mux_n_reg.sv - self-checking bench for mux_n_reg (4-channel and 3-channel instances)

module tb_mux_n_reg;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] ch [4];
    logic [127:0] D;
    logic [1:0]  SEL;
    logic        SEL_LD;
    logic [1:0]  SEL_Q;
    logic        IN_VALID, IN_READY;
    logic [31:0] Z;
    logic        OUT_VALID, OUT_READY;

    logic [23:0] D3;
    logic [1:0]  SEL3;
    logic        SEL_LD3;
    logic [1:0]  SEL_Q3;
    logic        IN_VALID3, IN_READY3;
    logic [7:0]  Z3;
    logic        OUT_VALID3;
`ifdef MUXN_SEL_CHECK_EN
    logic        SEL_ERR3;
`endif

    int checks   = 0;
    int failures = 0;

    assign D  = {ch[3], ch[2], ch[1], ch[0]};
    assign D3 = {8'h33, 8'h22, 8'h11};

    always #5 CLK = ~CLK;

    mux_n_reg #(.WIDTH(32), .CHANNELS(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST), .D(D), .SEL(SEL), .SEL_LD(SEL_LD), .SEL_Q(SEL_Q),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Z(Z), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY)
`ifdef MUXN_SEL_CHECK_EN
        , .SEL_ERR()
`endif
    );

    mux_n_reg #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .CLK(CLK), .nRST(nRST), .D(D3), .SEL(SEL3), .SEL_LD(SEL_LD3), .SEL_Q(SEL_Q3),
        .IN_VALID(IN_VALID3), .IN_READY(IN_READY3), .Z(Z3), .OUT_VALID(OUT_VALID3),
        .OUT_READY(1'b1)
`ifdef MUXN_SEL_CHECK_EN
        , .SEL_ERR(SEL_ERR3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model: beats accepted upstream are queued with the value of
    // the selected channel; the head of the queue is what Z must show.
    logic [31:0] exp_q[$];
    int          msel;
    int          n_in, n_out;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exp_q.delete();
            msel = 0;
        end else begin
            automatic bit room = (exp_q.size() == 0) || OUT_READY;
            if (OUT_READY && exp_q.size() != 0) void'(exp_q.pop_front());
            if (IN_VALID && room) exp_q.push_back(ch[msel]);
            if (SEL_LD) msel = int'(SEL);
        end
    end

    always @(posedge CLK) begin
        if (nRST) begin
            if (IN_VALID && IN_READY) n_in++;
            if (OUT_VALID && OUT_READY) n_out++;
        end
    end

    always @(negedge CLK) begin
        if (nRST) begin
            chk("cmp_sel_q", 32'(SEL_Q), 32'(msel));
            chk("cmp_out_valid", 32'(OUT_VALID), 32'(exp_q.size() != 0));
            chk("cmp_in_ready", 32'(IN_READY), 32'((exp_q.size() == 0) || OUT_READY));
            if (exp_q.size() != 0) chk("cmp_z", Z, exp_q[0]);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int base_in, base_out;
        n_in = 0; n_out = 0;
        nRST = 1'b0;
        ch[0] = 32'hAAAA0000; ch[1] = 32'hBBBB0001; ch[2] = 32'hCCCC0002; ch[3] = 32'hDDDD0003;
        SEL = '0; SEL_LD = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        SEL3 = '0; SEL_LD3 = 1'b0; IN_VALID3 = 1'b0;
        repeat (2) cyc();
        chk("rst_z", Z, 32'h0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'h0);
        chk("rst_sel_q", 32'(SEL_Q), 32'h0);
        chk("rst_in_ready", 32'(IN_READY), 32'h1);
        nRST = 1'b1;
        cyc();

        // basic select
        SEL = 2'd2; SEL_LD = 1'b1;
        cyc();
        SEL_LD = 1'b0; IN_VALID = 1'b1;
        cyc();
        IN_VALID = 1'b0;
        chk("basic_z", Z, 32'hCCCC0002);
        chk("basic_valid", 32'(OUT_VALID), 32'h1);

        // same-cycle load and capture
        SEL = 2'd1; SEL_LD = 1'b1;
        cyc();
        chk("sel1_loaded", 32'(SEL_Q), 32'h1);
        chk("drained", 32'(OUT_VALID), 32'h0);
        SEL = 2'd3; SEL_LD = 1'b1; IN_VALID = 1'b1;
        cyc();
        SEL_LD = 1'b0;
        chk("same_cyc_z_old_sel", Z, 32'hBBBB0001);
        chk("same_cyc_sel_q", 32'(SEL_Q), 32'h3);
        cyc();
        chk("next_beat_new_sel", Z, 32'hDDDD0003);

        // back-pressure: beat DDDD0003 pending, upstream holds a new beat
        OUT_READY = 1'b0;
        ch[3] = 32'h11110000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(IN_READY), 32'h0);
            cyc();
            chk("bp_z_hold", Z, 32'hDDDD0003);
            chk("bp_valid_hold", 32'(OUT_VALID), 32'h1);
        end
        base_in = n_in;
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("bp_release_z", Z, (i == 0) ? 32'h11110000 : 32'h00001000 + 32'(i));
            if (i == 0) base_out = n_out;
            ch[3] = 32'h00001001 + 32'(i);
            if (i == 7) IN_VALID = 1'b0;
        end
        cyc();
        chk("beats_in", 32'(n_in - base_in), 32'd8);
        chk("beats_out", 32'(n_out - base_out), 32'd8);
        chk("bp_drained", 32'(OUT_VALID), 32'h0);

        // streaming on channel 0
        SEL = 2'd0; SEL_LD = 1'b1;
        cyc();
        SEL_LD = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ch[0] = 32'(i);
            IN_VALID = 1'b1;
            cyc();
            chk("stream_z", Z, 32'(i));
            chk("stream_valid", 32'(OUT_VALID), 32'h1);
        end
        IN_VALID = 1'b0;
        cyc();

        // 3-channel instance: out-of-range select
        SEL3 = 2'd1; SEL_LD3 = 1'b1;
        cyc();
        chk("c3_sel1", 32'(SEL_Q3), 32'h1);
`ifdef MUXN_SEL_CHECK_EN
        chk("c3_err_valid_load", 32'(SEL_ERR3), 32'h0);
`endif
        SEL3 = 2'd3;
        cyc();
        SEL_LD3 = 1'b0;
`ifdef MUXN_SEL_CHECK_EN
        chk("c3_sel_rejected", 32'(SEL_Q3), 32'h1);
        chk("c3_err_pulse", 32'(SEL_ERR3), 32'h1);
        cyc();
        chk("c3_err_cleared", 32'(SEL_ERR3), 32'h0);
        IN_VALID3 = 1'b1;
        cyc();
        IN_VALID3 = 1'b0;
        chk("c3_z_ch1", 32'(Z3), 32'h22);
`else
        chk("c3_sel_oor", 32'(SEL_Q3), 32'h3);
        IN_VALID3 = 1'b1;
        cyc();
        IN_VALID3 = 1'b0;
        chk("c3_z_zero", 32'(Z3), 32'h0);
`endif
        chk("c3_valid", 32'(OUT_VALID3), 32'h1);
        cyc();

        // asynchronous reset with a pending beat
        SEL = 2'd2; SEL_LD = 1'b1; OUT_READY = 1'b0; IN_VALID = 1'b1;
        cyc();
        SEL_LD = 1'b0; IN_VALID = 1'b0;
        chk("pre_rst_valid", 32'(OUT_VALID), 32'h1);
        chk("pre_rst_sel", 32'(SEL_Q), 32'h2);
        #1 nRST = 1'b0;
        #1;
        chk("async_rst_z", Z, 32'h0);
        chk("async_rst_valid", 32'(OUT_VALID), 32'h0);
        chk("async_rst_sel", 32'(SEL_Q), 32'h0);
        chk("async_rst_in_ready", 32'(IN_READY), 32'h1);
        cyc();
        nRST = 1'b1;
        OUT_READY = 1'b1;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
